booth_r4_seq_mul: RTL

- Multi-cycle controller that sequences a radix-4 Booth multiply, one Booth digit per clock.
- Replaces the fully unrolled combinational multiplier where area matters, e.g. NTT butterfly twiddle products in the low-area configuration.
- Accepts signed operands over a valid/ready handshake.
- Returns a full-width signed product over a second valid/ready handshake.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_r4_digit.sv | 18 +
 rtl/booth_r4_seq_mul.sv | 63 ++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state, digit-code and digit-select types for the radix-4 Booth multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_PM1, SEL_PM2} sel_t;
  typedef struct packed {
    logic neg;
    sel_t sel;
  } digit_t;
  localparam logic [2:0] D_Z0  = 3'b000;
  localparam logic [2:0] D_P1A = 3'b001;
  localparam logic [2:0] D_P1B = 3'b010;
  localparam logic [2:0] D_P2  = 3'b011;
  localparam logic [2:0] D_N2  = 3'b100;
  localparam logic [2:0] D_N1A = 3'b101;
  localparam logic [2:0] D_N1B = 3'b110;
  localparam logic [2:0] D_Z1  = 3'b111;
  function automatic digit_t booth_decode(input logic [2:0] q);
    digit_t d;
    d.neg = q[2] && q != D_Z1;
    d.sel = (q == D_Z0 || q == D_Z1) ? SEL_ZERO : (q == D_P2 || q == D_N2) ? SEL_PM2 : SEL_PM1;
    return d;
  endfunction
endpackage

// File: rtl/booth_r4_digit.sv
// booth_r4_digit: combinational radix-4 Booth partial product from a 3-bit multiplier window
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int wO = 64
) (
  input  logic [2:0]    q,
  input  logic [wO-1:0] m,
  output logic [wO-1:0] pp
);
  digit_t d;
  logic [wO-1:0] mag;
  always_comb begin
    d = booth_decode(q);
    mag = d.sel == SEL_PM2 ? m << 1 : d.sel == SEL_PM1 ? m : '0;
    pp = d.neg ? -mag : mag;
  end
endmodule

// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: one-digit-per-clock radix-4 Booth multiplier with valid/ready in and out; BOOTH_EARLY_TERM_EN enables early termination
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int wI = 32,
  parameter int wO = 2 * wI
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iValid,
  output logic          oReady,
  input  logic [wI-1:0] iX,
  input  logic [wI-1:0] iY,
  output logic          oValid,
  input  logic          iReady,
  output logic [wO-1:0] oO,
  output logic          oBusy
);
  localparam int CW = $clog2(wI / 2);
  state_t state, state_n;
  logic [wO-1:0] m, acc, pp;
  logic [wI:0] q;
  logic [CW-1:0] cnt;
  logic last, skip;
  booth_r4_digit #(.wO(wO)) u_digit (.q(q[2:0]), .m(m), .pp(pp));
`ifdef BOOTH_EARLY_TERM_EN
  always_comb skip = q == '0 || q == '1;
`else
  always_comb skip = 1'b0;
`endif
  always_ff @(posedge iClk)
    state <= iRst ? IDLE : state_n;
  always_comb begin
    last = cnt == CW'(wI / 2 - 1);
    state_n = state == IDLE ? (iValid ? RUN : IDLE) :
              state == RUN  ? (skip || last ? DONE : RUN) :
              state == DONE ? (iReady ? IDLE : DONE) : IDLE;
    oReady = state == IDLE;
    oValid = state == DONE;
    oBusy = state != IDLE;
  end
  always_ff @(posedge iClk)
    if (iRst) begin
      m <= '0;
      q <= '0;
      acc <= '0;
      cnt <= '0;
      oO <= '0;
    end else if (state == IDLE && iValid) begin
      m <= wO'($signed(iX));
      q <= {iY, 1'b0};
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN && !skip) begin
      acc <= acc + pp;
      m <= m << 2;
      q <= $signed(q) >>> 2;
      cnt <= cnt + CW'(1);
      if (last) oO <= acc + pp;
    end else if (state == RUN) begin
      oO <= acc;
    end
endmodule
